// File: rtl/free_list_pkg.sv
// Shared types and sizing for the PRN free list, plus a popcount helper reused by ROB/map table.
package free_list_pkg;

    localparam int unsigned PRF       = 64;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned WAYS      = 2;
    localparam int unsigned FL_DEPTH  = PRF - ARCH_REGS;

    localparam int unsigned PRN_W  = $clog2(PRF);
    localparam int unsigned PTR_W  = $clog2(FL_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FL_DEPTH) + 1;
    localparam int unsigned WCNT_W = $clog2(WAYS + 1);

    typedef logic [PRN_W-1:0]  prn_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [CNT_W-1:0]  fl_cnt_t;
    typedef logic [WCNT_W-1:0] way_cnt_t;

    localparam fl_cnt_t FL_FULL = fl_cnt_t'(FL_DEPTH);

    function automatic way_cnt_t popcount(input logic [WAYS-1:0] v);
        way_cnt_t c;
        c = '0;
        for (int i = 0; i < WAYS; i++) c = c + way_cnt_t'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Dispatch/retire bus of the free list; debug observation signals exist only with FREE_LIST_DEBUG_EN.
interface free_list_if;
    import free_list_pkg::*;

    logic [WAYS-1:0]  alloc_en;
    prn_t [WAYS-1:0]  alloc_prn;
    logic [WAYS-1:0]  alloc_grant;
    fl_cnt_t          num_free;
    logic [WAYS-1:0]  retire_en;
    prn_t [WAYS-1:0]  retire_told_prn;
    logic             nuke;
`ifdef FREE_LIST_DEBUG_EN
    fl_ptr_t          head_out;
    fl_ptr_t          tail_out;
    fl_ptr_t          arch_head_out;
    logic             fl_error;

    modport master (output alloc_en, retire_en, retire_told_prn, nuke,
                    input  alloc_prn, alloc_grant, num_free,
                           head_out, tail_out, arch_head_out, fl_error);
    modport slave  (input  alloc_en, retire_en, retire_told_prn, nuke,
                    output alloc_prn, alloc_grant, num_free,
                           head_out, tail_out, arch_head_out, fl_error);
`else
    modport master (output alloc_en, retire_en, retire_told_prn, nuke,
                    input  alloc_prn, alloc_grant, num_free);
    modport slave  (input  alloc_en, retire_en, retire_told_prn, nuke,
                    output alloc_prn, alloc_grant, num_free);
`endif

endinterface

// File: rtl/free_list.sv
// Circular PRN free list with speculative head, retirement head and nuke rollback.
// Optional debug ports/assertions under FREE_LIST_DEBUG_EN.
module free_list
    import free_list_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    free_list_if.slave fl
);

    prn_t     r_entries [FL_DEPTH];
    fl_ptr_t  r_head;
    fl_ptr_t  r_arch_head;
    fl_ptr_t  r_tail;
    fl_cnt_t  r_count;

    logic [WAYS-1:0] w_grant;
    logic [WAYS-1:0] w_free_ok;
    fl_ptr_t         w_wr_idx [WAYS];
    way_cnt_t        w_n_alloc;
    way_cnt_t        w_n_free;

    // Compacting allocation: each granted way consumes the next entry from head.
    always_comb begin
        fl_cnt_t w_k;
        w_k       = '0;
        w_grant   = '0;
        fl.alloc_prn = '0;
        for (int i = 0; i < WAYS; i++) begin
            fl.alloc_prn[i] = r_entries[r_head + fl_ptr_t'(w_k)];
            w_grant[i]      = fl.alloc_en[i] & ~reset & ~fl.nuke & (r_count > w_k);
            w_k             = w_k + fl_cnt_t'(w_grant[i]);
        end
    end

    // Frees pack in slot order at tail; a free into a full list is dropped.
    always_comb begin
        fl_cnt_t w_f;
        w_f       = '0;
        w_free_ok = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_wr_idx[i]  = r_tail + fl_ptr_t'(w_f);
            w_free_ok[i] = fl.retire_en[i] & ((r_count + w_f) < FL_FULL);
            w_f          = w_f + fl_cnt_t'(w_free_ok[i]);
        end
    end

    assign w_n_alloc      = popcount(w_grant);
    assign w_n_free       = popcount(w_free_ok);
    assign fl.alloc_grant = w_grant;
    assign fl.num_free    = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) r_entries[i] <= prn_t'(ARCH_REGS + i);
            r_head      <= '0;
            r_arch_head <= '0;
            r_tail      <= '0;
            r_count     <= FL_FULL;
        end else begin
            for (int i = 0; i < WAYS; i++)
                if (w_free_ok[i]) r_entries[w_wr_idx[i]] <= fl.retire_told_prn[i];
            r_tail      <= r_tail + fl_ptr_t'(w_n_free);
            r_arch_head <= r_arch_head + fl_ptr_t'(w_n_free);
            // Rollback: everything past the retirement point becomes free again.
            if (fl.nuke) begin
                r_head  <= r_arch_head + fl_ptr_t'(w_n_free);
                r_count <= FL_FULL;
            end else begin
                r_head  <= r_head + fl_ptr_t'(w_n_alloc);
                r_count <= r_count - fl_cnt_t'(w_n_alloc) + fl_cnt_t'(w_n_free);
            end
        end
    end

`ifdef FREE_LIST_DEBUG_EN
    logic r_fl_error;
    logic r_reset_win;
    logic w_err;

    // Reset window lasts until the first PRN is handed out; no arch PRN can be stale before that.
    always_comb begin
        w_err = |(fl.retire_en & ~w_free_ok);
        for (int i = 0; i < WAYS; i++)
            if (r_reset_win && fl.retire_en[i] && (fl.retire_told_prn[i] < prn_t'(ARCH_REGS)))
                w_err = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fl_error  <= 1'b0;
            r_reset_win <= 1'b1;
        end else begin
            if (w_err)    r_fl_error  <= 1'b1;
            if (|w_grant) r_reset_win <= 1'b0;
        end
    end

    assign fl.head_out      = r_head;
    assign fl.tail_out      = r_tail;
    assign fl.arch_head_out = r_arch_head;
    assign fl.fl_error      = r_fl_error;

    a_count_max: assert property (@(posedge clock) disable iff (reset) r_count <= FL_FULL);
`endif

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed vector table plus randomized traffic against a queue-based model.
module tb_free_list;
    import free_list_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    free_list_if u_if ();
    free_list dut (.clock(clk), .reset(rst), .fl(u_if.slave));

    typedef struct {
        logic       r;
        logic [1:0] en;
        logic [1:0] ren;
        prn_t       t0;
        prn_t       t1;
        logic       nk;
        logic [1:0] g;
        prn_t       p0;
        prn_t       p1;
        int         nf;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model: list in order from the retirement point = unretired allocations, then free PRNs.
    prn_t aq[$];
    prn_t fq[$];

    function automatic vec_t mk(logic r, logic [1:0] en, logic [1:0] ren, int t0, int t1,
                                logic nk, logic [1:0] g, int p0, int p1, int nf);
        vec_t v;
        v.r = r; v.en = en; v.ren = ren; v.t0 = prn_t'(t0); v.t1 = prn_t'(t1);
        v.nk = nk; v.g = g; v.p0 = prn_t'(p0); v.p1 = prn_t'(p1); v.nf = nf;
        return v;
    endfunction

    task automatic model_reset();
        aq.delete();
        fq.delete();
        for (int i = 0; i < 32; i++) fq.push_back(prn_t'(32 + i));
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input bit tab);
        logic [1:0] g;
        prn_t       p [2];
        prn_t       t [2];
        bit         acc [2];
        int         k;
        int         j;
        @(negedge clk);
        rst                   = v.r;
        u_if.alloc_en         = v.en;
        u_if.retire_en        = v.ren;
        u_if.retire_told_prn[0] = v.t0;
        u_if.retire_told_prn[1] = v.t1;
        u_if.nuke             = v.nk;
        #1;
        g = '0; k = 0; p[0] = '0; p[1] = '0;
        t[0] = v.t0; t[1] = v.t1;
        for (int i = 0; i < 2; i++)
            if (!v.r && !v.nk && v.en[i] && fq.size() > k) begin
                g[i] = 1'b1; p[i] = fq[k]; k++;
            end
        chk("grant", int'(u_if.alloc_grant), int'(g));
        for (int i = 0; i < 2; i++)
            if (g[i]) chk($sformatf("prn%0d", i), int'(u_if.alloc_prn[i]), int'(p[i]));
        chk("num_free", int'(u_if.num_free), fq.size());
        if (tab) begin
            chk("tab_grant", int'(u_if.alloc_grant), int'(v.g));
            if (v.g[0]) chk("tab_prn0", int'(u_if.alloc_prn[0]), int'(v.p0));
            if (v.g[1]) chk("tab_prn1", int'(u_if.alloc_prn[1]), int'(v.p1));
            if (v.nf >= 0) chk("tab_num_free", int'(u_if.num_free), v.nf);
        end
        @(posedge clk);
        if (v.r) begin
            model_reset();
        end else begin
            j = 0;
            for (int i = 0; i < 2; i++) begin
                acc[i] = v.ren[i] && (fq.size() + j < 32);
                if (acc[i]) j++;
            end
            repeat (k) aq.push_back(fq.pop_front());
            for (int i = 0; i < 2; i++)
                if (acc[i]) begin
                    void'(aq.pop_front());
                    fq.push_back(t[i]);
                end
            if (v.nk) begin
                fq = {aq, fq};
                aq.delete();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        u_if.alloc_en = '0;
        u_if.retire_en = '0;
        u_if.retire_told_prn = '0;
        u_if.nuke = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Drain the list two per cycle, then stall on empty
        for (int c = 0; c < 16; c++) vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 32+2*c, 33+2*c, 32-2*c));
        vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0));
        // count==1 with two requests, then way-1-only request
        vq.push_back(mk(0, 2'b00, 2'b01, 3, 0, 0, 2'b00, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b01, 3, 0, 1));
        vq.push_back(mk(0, 2'b11, 2'b01, 9, 0, 0, 2'b00, 0, 0, 0));
        vq.push_back(mk(0, 2'b10, 2'b00, 0, 0, 0, 2'b10, 0, 9, 1));
        vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0));
        // Free into a full list is dropped
        vq.push_back(mk(1, 2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0));
        vq.push_back(mk(0, 2'b00, 2'b01, 3, 0, 0, 2'b00, 0, 0, 32));
        vq.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 2'b01, 32, 0, 32));
        // Free 5,7 and see them again after wrap-around
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, -1));
        vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 32, 33, 32));
        vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 34, 35, 30));
        vq.push_back(mk(0, 2'b00, 2'b11, 5, 7, 0, 2'b00, 0, 0, 28));
        for (int c = 0; c < 14; c++) vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 36+2*c, 37+2*c, 30-2*c));
        vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 5, 7, 2));
        vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0));
        // Nuke together with a two-wide retire
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, -1));
        for (int c = 0; c < 3; c++) vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 32+2*c, 33+2*c, 32-2*c));
        vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 1, 2'b00, 0, 0, 26));
        vq.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 2'b01, 34, 0, 32));
        // Reset mid-operation with count==10 and overwritten entries
        vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, -1));
        for (int c = 0; c < 12; c++) vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 32+2*c, 33+2*c, 32-2*c));
        vq.push_back(mk(0, 2'b00, 2'b11, 11, 12, 0, 2'b00, 0, 0, 8));
        vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 10));
        vq.push_back(mk(1, 2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0, 10));
        vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 32, 33, 32));

        foreach (vq[i]) apply(vq[i], 1'b1);

        for (int c = 0; c < 3000; c++) begin
            vec_t v;
            v = mk(($urandom_range(499) == 0), 2'($urandom), 2'b00,
                   int'($urandom_range(63)), int'($urandom_range(63)),
                   ($urandom_range(31) == 0), 2'b00, 0, 0, -1);
            if (aq.size() > 0 || $urandom_range(15) == 0) v.ren = 2'($urandom);
            apply(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
